alu_seq: RTL and testbench

- Registered, handshaked successor to the combinational datapath ALU, parametrised in WIDTH.
- Owns the architectural NZCV flag register, so carry-in and flag hold come from internal state rather than from ports.
- Adds a multi-cycle iterative multiply opcode.
- Sits between the operand/shift stage and the writeback stage of the multi-cycle CPU.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_mul_iter.sv | 74 +++++++
 rtl/alu_seq.sv | 173 +++++++++++++++++
 tb/tb_alu_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag index and FSM state definitions shared by alu_seq and its multiplier
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_EOR  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_RSB  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_ADC  = 4'h5;
    localparam logic [3:0] OP_SBC  = 4'h6;
    localparam logic [3:0] OP_RSC  = 4'h7;
    localparam logic [3:0] OP_MOVA = 4'h8;
    localparam logic [3:0] OP_MUL  = 4'h9;
    localparam logic [3:0] OP_SUB4 = 4'hA;
    localparam logic [3:0] OP_ZERO = 4'hB;
    localparam logic [3:0] OP_ORR  = 4'hC;
    localparam logic [3:0] OP_MOVB = 4'hD;
    localparam logic [3:0] OP_BIC  = 4'hE;
    localparam logic [3:0] OP_MVN  = 4'hF;

    localparam int FN = 3;
    localparam int FZ = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, low WIDTH bits of unsigned a*b
module alu_mul_iter #(
    parameter int WIDTH              = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int ITERS = WIDTH / MUL_BITS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS + 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] partial;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;

    // done/product look ahead at the final iteration so the caller can register on the same edge
    assign done    = run_q && (cnt_q == CW'(ITERS - 1));
    assign product = acc_q + partial;

    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
            if (mplier_q[j]) begin
                partial = partial + (mcand_q << j);
            end
        end
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << MUL_BITS_PER_CYCLE;
            mplier_d = mplier_q >> MUL_BITS_PER_CYCLE;
            cnt_d    = cnt_q + CW'(1);
            if (done) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered handshaked ALU owning NZCV; ALU_SEQ_MUL_EN builds the iterative multiply for op 0x9
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH              = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_OP,
    input  logic             S,
    input  logic             shiftCout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic [3:0]       NZCV,
    output logic             busy
);

    if (MUL_BITS_PER_CYCLE < 1 || MUL_BITS_PER_CYCLE > 2 || WIDTH < 8 ||
        (WIDTH % MUL_BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("alu_seq: unsupported WIDTH/MUL_BITS_PER_CYCLE");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic [3:0]       nzcv_q, nzcv_d;

    logic [WIDTH-1:0] x, y, alu_res;
    logic             cin, alu_c, alu_v;
    logic [WIDTH:0]   sum, sum4;

`ifdef ALU_SEQ_MUL_EN
    logic             s_q, s_d;
    logic             mul_start, mul_done;
    logic [WIDTH-1:0] mul_product;

    alu_mul_iter #(
        .WIDTH              (WIDTH),
        .MUL_BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );

    assign busy = (state_q == MUL);
`else
    assign busy = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign F         = f_q;
    assign NZCV      = nzcv_q;

    // One shared adder: every arithmetic op is X + Y' + cin with Y' possibly inverted
    always_comb begin
        x   = A;
        y   = B;
        cin = 1'b0;
        case (ALU_OP)
            OP_SUB, OP_SUB4: begin y = ~B; cin = 1'b1; end
            OP_RSB:          begin x = B; y = ~A; cin = 1'b1; end
            OP_ADC:          cin = nzcv_q[FC];
            OP_SBC:          begin y = ~B; cin = nzcv_q[FC]; end
            OP_RSC:          begin x = B; y = ~A; cin = nzcv_q[FC]; end
            default:         ;
        endcase
        sum  = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        sum4 = {1'b0, sum[WIDTH-1:0]} + (WIDTH+1)'(4);

        alu_res = '0;
        alu_c   = nzcv_q[FC];
        alu_v   = nzcv_q[FV];
        case (ALU_OP)
            OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (x[WIDTH-1] == y[WIDTH-1]) && (alu_res[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB4: begin
                alu_res = sum4[WIDTH-1:0];
                alu_c   = sum[WIDTH] | sum4[WIDTH];
                alu_v   = (x[WIDTH-1] == y[WIDTH-1]) && (alu_res[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND:  begin alu_res = A & B;  alu_c = shiftCout; end
            OP_EOR:  begin alu_res = A ^ B;  alu_c = shiftCout; end
            OP_MOVA: begin alu_res = A;      alu_c = shiftCout; end
            OP_ORR:  begin alu_res = A | B;  alu_c = shiftCout; end
            OP_MOVB: begin alu_res = B;      alu_c = shiftCout; end
            OP_BIC:  begin alu_res = A & ~B; alu_c = shiftCout; end
            OP_MVN:  begin alu_res = ~B;     alu_c = shiftCout; end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        nzcv_d  = nzcv_q;
`ifdef ALU_SEQ_MUL_EN
        s_d       = s_q;
        mul_start = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (ALU_OP == OP_MUL) begin
                        s_d       = S;
                        mul_start = 1'b1;
                        state_d   = MUL;
                    end else begin
`else
                    begin
`endif
                        f_d = alu_res;
                        if (S) begin
                            nzcv_d = {alu_res[WIDTH-1], ~|alu_res, alu_c, alu_v};
                        end
                        state_d = DONE;
                    end
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                if (mul_done) begin
                    f_d = mul_product;
                    if (s_q) begin
                        nzcv_d[FN] = mul_product[WIDTH-1];
                        nzcv_d[FZ] = ~|mul_product;
                    end
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            f_q     <= '0;
            nzcv_q  <= '0;
`ifdef ALU_SEQ_MUL_EN
            s_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            nzcv_q  <= nzcv_d;
`ifdef ALU_SEQ_MUL_EN
            s_q     <= s_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed plus randomized checks of alu_seq against an arithmetic reference model
module tb_alu_seq;

    localparam int W   = 32;
    localparam int BPC = 1;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int MUL_LAT = W / BPC + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] A, B, F;
    logic [3:0]   ALU_OP, NZCV;
    logic         S, shiftCout, busy;

    int         n_vec  = 0;
    int         n_miss = 0;
    logic [3:0] m_nzcv;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .MUL_BITS_PER_CYCLE(BPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALU_OP    (ALU_OP),
        .S         (S),
        .shiftCout (shiftCout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F         (F),
        .NZCV      (NZCV),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit s_ovf(input longint v);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    // Returns {nzcv, f} from integer arithmetic on the operands
    function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic sc, input logic [3:0] fl);
        longint          sa, sb;
        longint unsigned ua, ub, full;
        logic [31:0]     r;
        logic            c, v, ci, lg;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        ci = fl[1];
        c  = fl[1];
        v  = fl[0];
        lg = 1'b0;
        r  = '0;
        case (op)
            4'h0: begin r = a & b; lg = 1'b1; end
            4'h1: begin r = a ^ b; lg = 1'b1; end
            4'h2: begin r = a - b; c = (ua >= ub); v = s_ovf(sa - sb); end
            4'h3: begin r = b - a; c = (ub >= ua); v = s_ovf(sb - sa); end
            4'h4: begin full = ua + ub; r = full[31:0]; c = full[32]; v = s_ovf(sa + sb); end
            4'h5: begin full = ua + ub + ci; r = full[31:0]; c = full[32]; v = s_ovf(sa + sb + ci); end
            4'h6: begin r = a - b + ci - 1; c = (ua + ci > ub); v = s_ovf(sa - sb + ci - 1); end
            4'h7: begin r = b - a + ci - 1; c = (ub + ci > ua); v = s_ovf(sb - sa + ci - 1); end
            4'h8: begin r = a; lg = 1'b1; end
            4'h9: begin full = ua * ub; r = MUL_EN ? full[31:0] : 32'h0; end
            4'hA: begin
                r = a - b + 4;
                c = (ua >= ub) || ((((ua - ub) & 64'hFFFF_FFFF) + 4) >= 64'h1_0000_0000);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'hB: r = '0;
            4'hC: begin r = a | b; lg = 1'b1; end
            4'hD: begin r = b; lg = 1'b1; end
            4'hE: begin r = a & ~b; lg = 1'b1; end
            default: begin r = ~b; lg = 1'b1; end
        endcase
        if (lg) c = sc;
        return s ? {r[31], (r == 0), c, v, r} : {fl, r};
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic sc, input logic [31:0] exp_f,
                          input logic [3:0] exp_nzcv, input int exp_lat, input int hold,
                          input string tag);
        int lat;
        int busy_cnt;
        check({tag, "_in_ready"}, in_ready, 1);
        ALU_OP = op; A = a; B = b; S = s; shiftCout = sc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        ALU_OP = 4'($urandom); S = 1'($urandom); shiftCout = 1'($urandom);
        lat = 1;
        busy_cnt = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (busy === 1'b1 && in_ready === 1'b0) busy_cnt++;
            A = $urandom; B = $urandom;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
        check({tag, "_F"}, F, exp_f);
        check({tag, "_NZCV"}, NZCV, exp_nzcv);
        repeat (hold) begin
            in_valid = 1'b1; ALU_OP = 4'($urandom); A = $urandom; S = 1'b1;
            @(negedge clk);
            check({tag, "_hold_F"}, F, exp_f);
            check({tag, "_hold_NZCV"}, NZCV, exp_nzcv);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        logic [35:0] exp;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        s, sc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; ALU_OP = '0; S = 1'b0; shiftCout = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_F", F, 0);
        check("rst_NZCV", NZCV, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(4'h4, 32'hFFFF_FFFF, 32'h1, 1, 0, 32'h0, 4'b0110, 1, 0, "add_wrap");
        run_op(4'h2, 32'h8000_0000, 32'h1, 1, 0, 32'h7FFF_FFFF, 4'b0011, 1, 0, "sub_ovf");
        run_op(4'h5, 32'h1, 32'h1, 0, 0, 32'h3, 4'b0011, 1, 0, "adc_nos");
        run_op(4'h9, 32'h7, 32'h6, 1, 0, MUL_EN ? 32'd42 : 32'd0,
               MUL_EN ? 4'b0011 : 4'b0111, MUL_EN ? MUL_LAT : 1, 0, "mul");
        run_op(4'h0, 32'hF0, 32'h0F, 1, 1, 32'h0, 4'b0111, 1, 5, "and_hold");
        run_op(4'h5, 32'h1, 32'h1, 1, 0, 32'h3, 4'b0000, 1, 0, "b2b_adc");
        run_op(4'h2, 32'h0, 32'h1, 1, 0, 32'hFFFF_FFFF, 4'b1000, 1, 0, "sub_borrow");

        // Reset during multiply iteration 10 (or in DONE when the multiplier is not built)
        check("pre_rst_in_ready", in_ready, 1);
        ALU_OP = 4'h9; A = 32'h1234_5678; B = 32'h9ABC_DEF1; S = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_F", F, 0);
        check("midrst_NZCV", NZCV, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(4'h8, 32'h5, 32'hDEAD_BEEF, 0, 0, 32'h5, 4'b0000, 1, 0, "mov_after_rst");

        m_nzcv = 4'b0000;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: a = 32'h0;
                1: a = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: b = 32'h1;
                1: b = 32'h7FFF_FFFF;
                2: b = a;
                default: b = $urandom;
            endcase
            s  = 1'($urandom_range(0, 1));
            sc = 1'($urandom_range(0, 1));
            exp = model(op, a, b, s, sc, m_nzcv);
            m_nzcv = exp[35:32];
            run_op(op, a, b, s, sc, exp[31:0], exp[35:32],
                   (op == 4'h9 && MUL_EN) ? MUL_LAT : 1, $urandom_range(0, 2), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
